// File: rtl/cpu6_prog_loader_if.sv
// Serial program-load bus for cpu6_prog_loader.
// The slave modport is the loader; the master modport is the host or bench.
interface cpu6_prog_loader_if #(
  parameter int WORD_W = 6,
  parameter int DEPTH  = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/cpu6_prog_loader.sv
// Serial-to-parallel instruction-memory loader that holds the CPU while loading.
// Define PROG_CHECKSUM_EN to receive and check a trailing XOR checksum word.
module cpu6_prog_loader #(
  parameter int WORD_W = 6,
  parameter int DEPTH  = 8
) (
  input logic               clk,
  input logic               rst,
  cpu6_prog_loader_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
`ifdef PROG_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] shreg_reg;
  logic [AW-1:0]     word_cnt_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              bit_ready_reg;
  logic              wr_en_reg;
  logic [AW-1:0]     wr_addr_reg;
  logic [WORD_W-1:0] wr_data_reg;
  logic              cpu_hold_reg;
  logic              done_reg;
`ifdef PROG_CHECKSUM_EN
  logic [WORD_W-1:0] acc_reg;
  logic              err_reg;
`endif

  logic              xfer;
  logic [WORD_W-1:0] shifted;

  assign xfer    = bus.bit_valid & bit_ready_reg;
  assign shifted = {shreg_reg[WORD_W-2:0], bus.bit_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      word_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      bit_ready_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      cpu_hold_reg  <= 1'b0;
      done_reg      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      acc_reg       <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg     <= SHIFT;
            shreg_reg     <= '0;
            word_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            bit_ready_reg <= 1'b1;
            cpu_hold_reg  <= 1'b1;
            done_reg      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
            acc_reg       <= '0;
            err_reg       <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (xfer) begin
            shreg_reg   <= shifted;
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            // Outputs for the WRITE cycle are registered here so they line up with the state.
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg     <= WRITE;
              bit_ready_reg <= 1'b0;
              wr_en_reg     <= 1'b1;
              wr_addr_reg   <= word_cnt_reg;
              wr_data_reg   <= shifted;
`ifdef PROG_CHECKSUM_EN
              acc_reg       <= acc_reg ^ shifted;
`endif
            end
          end
        end

        WRITE: begin
          bit_cnt_reg <= '0;
          if (word_cnt_reg == LAST_WORD) begin
`ifdef PROG_CHECKSUM_EN
            state_reg     <= CHECK;
            bit_ready_reg <= 1'b1;
`else
            state_reg     <= DONE;
            cpu_hold_reg  <= 1'b0;
            done_reg      <= 1'b1;
`endif
          end else begin
            state_reg     <= SHIFT;
            word_cnt_reg  <= word_cnt_reg + AW'(1);
            bit_ready_reg <= 1'b1;
          end
        end

`ifdef PROG_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            shreg_reg   <= shifted;
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg     <= DONE;
              bit_ready_reg <= 1'b0;
              cpu_hold_reg  <= 1'b0;
              done_reg      <= 1'b1;
              err_reg       <= (shifted != acc_reg);
            end
          end
        end
`endif

        default: begin
          state_reg     <= IDLE;
          bit_ready_reg <= 1'b0;
          cpu_hold_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_ready = bit_ready_reg;
  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.cpu_hold  = cpu_hold_reg;
  assign bus.done      = done_reg;
`ifdef PROG_CHECKSUM_EN
  assign bus.err       = err_reg;
`else
  assign bus.err       = 1'b0;
`endif
endmodule
